// File: rtl/rf_copy_engine.sv
// rf_copy_engine
//   Copies len rows inside the register file, one row at a time, using a
//   read / capture / write sequence on the shared RF access port. The
//   sequencer uses it to move BRAM rows into EU X-load addresses and EU
//   Y-output rows back into BRAM.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle request, only honoured in IDLE
//   src_addr, dst_addr    first source / destination row
//   len                   number of rows (0 = no transfer, just done)
//   src_inc, dst_inc      1 = step the address per row, 0 = hold it
//   busy, done            busy in RD/CAP/WR; done pulses in FIN
//   rf_addr, rf_we, rf_re RF access address and strobes
//   rf_d                  RF write data (registered)
//   rf_q                  RF read data, valid the cycle after rf_re
module rf_copy_engine #(
  parameter int RF_DATA_W = 1408,
  parameter int RF_ADDR_W = 10,
  parameter int LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RF_ADDR_W-1:0] src_addr,
  input  logic [RF_ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]     len,
  input  logic                 src_inc,
  input  logic                 dst_inc,
  output logic                 busy,
  output logic                 done,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic                 rf_we,
  output logic                 rf_re,
  output logic [RF_DATA_W-1:0] rf_d,
  input  logic [RF_DATA_W-1:0] rf_q
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t                 state, state_nx;
  logic [RF_ADDR_W-1:0]   src_reg, dst_reg;
  logic [LEN_W-1:0]       count;
  logic                   sinc, dinc;
  logic [RF_DATA_W-1:0]   data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      src_reg  <= '0;
      dst_reg  <= '0;
      count    <= '0;
      sinc     <= 1'b0;
      dinc     <= 1'b0;
      data_reg <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          src_reg <= src_addr;
          dst_reg <= dst_addr;
          count   <= len;
          sinc    <= src_inc;
          dinc    <= dst_inc;
        end
        // rf_q now carries the row requested in RD
        CAP: data_reg <= rf_q;
        WR: begin
          count   <= count - LEN_W'(1);
          // address arithmetic wraps naturally at the top of the RF
          src_reg <= src_reg + RF_ADDR_W'(sinc);
          dst_reg <= dst_reg + RF_ADDR_W'(dinc);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rf_re    = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = src_reg;
    case (state)
      IDLE: if (start) state_nx = (len == '0) ? FIN : RD;
      RD: begin
        busy     = 1'b1;
        rf_re    = 1'b1;
        state_nx = CAP;
      end
      CAP: begin
        busy     = 1'b1;
        state_nx = WR;
      end
      WR: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_addr  = dst_reg;
        state_nx = (count != LEN_W'(1)) ? RD : FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // write data comes straight from the capture register, so rf_d only
  // changes at the end of CAP and holds otherwise
  assign rf_d = data_reg;

endmodule

// File: tb/tb_rf_copy_engine.sv
module tb_rf_copy_engine;
  localparam int DW = 1408;
  localparam int AW = 10;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          src_inc, dst_inc;
  logic          busy, done, rf_we, rf_re;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d, rf_q;

  int checks = 0;
  int errors = 0;
  logic [7:0] seed = 8'd0;

  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];
  logic [DW-1:0] wd_q[$];

  rf_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .src_inc(src_inc), .dst_inc(dst_inc),
    .busy(busy), .done(done), .rf_addr(rf_addr), .rf_we(rf_we),
    .rf_re(rf_re), .rf_d(rf_d), .rf_q(rf_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [7:0] s);
    logic [31:0] w;
    w = {s, 6'd0, a, 8'h5A};
    return {44{w}};
  endfunction

  // RF model: reads return a per-address pattern one cycle after rf_re
  always @(posedge clk) if (rf_re) rf_q <= pat(rf_addr, seed);

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          si;
    logic          di;
    int            xs;       // cycle at which a second start is driven, -1 none
    int            exp_done; // cycle index of done, start cycle = 0
  } vec_t;

  int ov_n;

  task automatic sample(inout int busy_n);
    if (rf_re) rd_q.push_back(rf_addr);
    if (rf_we) begin
      wr_q.push_back(rf_addr);
      wd_q.push_back(rf_d);
    end
    if (rf_re && rf_we) ov_n++;
    if (busy) busy_n++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, done_cyc, busy_n, post_n, n;
    logic [AW-1:0] ea, ew;
    logic [DW-1:0] ed;
    rd_q.delete(); wr_q.delete(); wd_q.delete();
    seed = seed + 8'd1;
    ov_n = 0; busy_n = 0; post_n = 0; done_cyc = -1;
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len;
    src_inc = v.si; dst_inc = v.di; start = 1'b1;
    for (cyc = 0; cyc < v.exp_done + 10; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        start = (cyc == v.xs);
        if (start) begin
          src_addr = 10'h3A0; dst_addr = 10'h3B0; len = 10'd5;
        end
      end
      sample(busy_n);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      start = 1'b0;
      if (rf_re || rf_we || busy || done) post_n++;
    end
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d busy_cycles", idx), busy_n, 3 * v.len);
    check($sformatf("v%0d reads", idx), rd_q.size(), v.len);
    check($sformatf("v%0d writes", idx), wr_q.size(), v.len);
    check($sformatf("v%0d post_activity", idx), post_n, 0);
    check($sformatf("v%0d strobe_overlap", idx), ov_n, 0);
    n = (rd_q.size() < wr_q.size()) ? rd_q.size() : wr_q.size();
    if (n > int'(v.len)) n = v.len;
    ea = v.src; ew = v.dst;
    for (int i = 0; i < n; i++) begin
      ed = pat(ea, seed);
      check($sformatf("v%0d rd_addr[%0d]", idx, i), rd_q[i], ea);
      check($sformatf("v%0d wr_addr[%0d]", idx, i), wr_q[i], ew);
      checks++;
      if (wd_q[i] !== ed) begin
        errors++;
        $display("FAIL v%0d wr_data[%0d]: got %h expected %h (low 64 bits)",
                 idx, i, wd_q[i][63:0], ed[63:0]);
      end
      ea = ea + AW'(v.si);
      ew = ew + AW'(v.di);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int wr_n, post_n;
    vecs[0] = '{10'h005, 10'h010, 10'd1, 1'b1, 1'b1, -1, 4};   // single row
    vecs[1] = '{10'h100, 10'h180, 10'd4, 1'b1, 1'b1, -1, 13};  // burst
    vecs[2] = '{10'h020, 10'h200, 10'd3, 1'b1, 1'b0, -1, 10};  // fixed dst
    vecs[3] = '{10'h030, 10'h040, 10'd0, 1'b1, 1'b1, -1, 1};   // len 0
    vecs[4] = '{10'h3FF, 10'h300, 10'd2, 1'b1, 1'b1, -1, 7};   // src wrap
    vecs[5] = '{10'h060, 10'h070, 10'd2, 1'b1, 1'b1, 3, 7};    // start in WR
    vecs[6] = '{10'h050, 10'h050, 10'd1, 1'b1, 1'b1, 4, 4};    // src==dst, start in FIN
    vecs[7] = '{10'h090, 10'h0A0, 10'd2, 1'b0, 1'b1, -1, 7};   // fixed src

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    src_inc = 1'b0; dst_inc = 1'b0;
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst rf_we", rf_we, 0);
    check("rst rf_re", rf_re, 0);
    check("rst rf_addr", rf_addr, 0);
    check("rst rf_d_zero", (rf_d == '0), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // reset during CAP of row 2 of a len=4 copy
    wr_q.delete();
    @(negedge clk);
    src_addr = 10'h110; dst_addr = 10'h120; len = 10'd4;
    src_inc = 1'b1; dst_inc = 1'b1; start = 1'b1;
    wr_n = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rf_we) wr_n++;
    end
    check("mid busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("mid rf_we", rf_we, 0);
    check("mid rf_re", rf_re, 0);
    check("mid busy", busy, 0);
    check("mid done", done, 0);
    check("mid writes_before_rst", wr_n, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    post_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rf_we || rf_re || busy || done) post_n++;
    end
    check("mid post_rst_activity", post_n, 0);
    run_vec(8, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
